seq_and_or_pipe: RTL and testbench

- Parametrised, handshaked successor to the single-bit sequential AND-OR block.
- Per-bit logic on WIDTH-bit vectors, with a selectable AND-OR / OR-AND mode.
- Fully aligned 2-stage pipeline with valid/ready backpressure, synchronous flush and a saturating transfer counter.
- Sits between operand sources and a downstream consumer that may stall.

---
 rtl/seq_and_or_pipe.sv | 112 +++++++++++
 tb/tb_seq_and_or_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_and_or_pipe.sv
// rtl/seq_and_or_pipe.sv - two-stage handshaked AND-OR / OR-AND datapath
// Stage 1 forms j1 and captures the second-term operands; stage 2 adds both terms.
module seq_and_or_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   n,
  output logic [CNT_W-1:0] xfer_cnt
);

  function automatic logic [WIDTH-1:0] f_op(
    input logic [WIDTH-1:0] p,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] s,
    input logic             m
  );
    return m ? ((p | q) & (r | s)) : ((p & q) | (r & s));
  endfunction

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] j1_q, j1_d;
  logic [WIDTH-1:0] k1_q, k1_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic [WIDTH-1:0] f1_q, f1_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic             mode1_q, mode1_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   n_q, n_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic             adv;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign n         = n_q;
  assign xfer_cnt  = xfer_cnt_q;

  always_comb begin
    v1_d        = v1_q;
    j1_d        = j1_q;
    k1_d        = k1_q;
    e1_d        = e1_q;
    f1_d        = f1_q;
    g1_d        = g1_q;
    mode1_d     = mode1_q;
    out_valid_d = out_valid_q;
    n_d         = n_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (adv) begin
      j1_d        = f_op(a, b, c, d, mode);
      k1_d        = c & d;
      e1_d        = e;
      f1_d        = f;
      g1_d        = g;
      mode1_d     = mode;
      v1_d        = in_valid;
      n_d         = {1'b0, j1_q} + {1'b0, f_op(k1_q, e1_q, f1_q, g1_q, mode1_q)};
      out_valid_d = v1_q;
    end
    // Flush only kills valids; a transfer finishing on the same edge still counts.
    if (flush) begin
      v1_d        = 1'b0;
      out_valid_d = 1'b0;
    end
    if (out_valid_q && out_ready && (xfer_cnt_q != {CNT_W{1'b1}})) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      j1_q        <= '0;
      k1_q        <= '0;
      e1_q        <= '0;
      f1_q        <= '0;
      g1_q        <= '0;
      mode1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      n_q         <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      v1_q        <= v1_d;
      j1_q        <= j1_d;
      k1_q        <= k1_d;
      e1_q        <= e1_d;
      f1_q        <= f1_d;
      g1_q        <= g1_d;
      mode1_q     <= mode1_d;
      out_valid_q <= out_valid_d;
      n_q         <= n_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_and_or_pipe.sv
// tb/tb_seq_and_or_pipe.sv - directed vector bench for seq_and_or_pipe
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_seq_and_or_pipe;

  typedef struct {
    logic       mode;
    logic [3:0] a, b, c, d, e, f, g;
    logic [4:0] exp_n;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, mode = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [3:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0, g = '0;
  logic       in_ready, out_valid, in_ready2, out_valid2;
  logic [4:0] n, n2;
  logic [7:0] xfer_cnt;
  logic [1:0] xfer_cnt2;

  int checks = 0;
  int errors = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  seq_and_or_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .n(n), .xfer_cnt(xfer_cnt)
  );

  seq_and_or_pipe #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .mode(mode),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .n(n2), .xfer_cnt(xfer_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in_valid = vld;
    mode = v.mode;
    a = v.a; b = v.b; c = v.c; d = v.d; e = v.e; f = v.f; g = v.g;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1 rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'hF, 4'h3, 4'h5, 4'h5, 4'hF, 4'h0, 4'h0, 5'h0C};
    vecs[1] = '{1'b1, 4'hF, 4'h3, 4'h5, 4'h5, 4'hF, 4'h0, 4'h0, 5'h05};
    vecs[2] = '{1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 5'h1E};
    vecs[3] = '{1'b1, 4'hA, 4'h5, 4'h3, 4'hC, 4'h0, 4'h8, 4'h1, 5'h0F};
    vecs[4] = '{1'b0, 4'hC, 4'hA, 4'h6, 4'h3, 4'h9, 4'h4, 4'h6, 5'h0E};
    vecs[5] = '{1'b1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'h1, 4'h2, 5'h02};

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_n", n, 5'h00);
    chk("rst_xfer_cnt", xfer_cnt, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b1;

    // Single operand set, latency and first transfer
    out_ready = 1'b1;
    drive(vecs[0], 1'b1);
    step();
    chk("single_ov_after_accept", out_valid, 1'b0);
    in_valid = 1'b0;
    step();
    chk("single_ov", out_valid, 1'b1);
    chk("single_n", n, 5'h0C);
    chk("single_cnt_before", xfer_cnt, 8'd0);
    step();
    chk("single_cnt_after", xfer_cnt, 8'd1);
    chk("single_bubble", out_valid, 1'b0);

    // Back-to-back table run, mode alternating between sets
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(vecs[i], 1'b1);
      else in_valid = 1'b0;
      step();
      if (i >= 1) begin
        chk($sformatf("tbl_ov_%0d", i - 1), out_valid, 1'b1);
        chk($sformatf("tbl_n_%0d", i - 1), n, {27'd0, vecs[i - 1].exp_n});
      end
    end
    step();
    chk("tbl_cnt", xfer_cnt, 8'd6);
    chk("tbl_drain", out_valid, 1'b0);

    // Backpressure: three inputs, consumer stalls
    do_reset();
    out_ready = 1'b0;
    drive(vecs[0], 1'b1);
    step();
    drive(vecs[1], 1'b1);
    step();
    drive(vecs[2], 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_in_ready_%0d", k), in_ready, 1'b0);
      chk($sformatf("bp_hold_n_%0d", k), n, 5'h0C);
      chk($sformatf("bp_hold_ov_%0d", k), out_valid, 1'b1);
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp_in_ready_release", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_res1", n, 5'h05);
    chk("bp_cnt1", xfer_cnt, 8'd1);
    step();
    chk("bp_res2", n, 5'h1E);
    chk("bp_res2_ov", out_valid, 1'b1);
    step();
    chk("bp_empty", out_valid, 1'b0);
    chk("bp_cnt", xfer_cnt, 8'd3);

    // Flush with both stages full; input on that edge is dropped, transfer still counts
    do_reset();
    out_ready = 1'b0;
    drive(vecs[0], 1'b1);
    step();
    drive(vecs[1], 1'b1);
    step();
    chk("fl_pre_ov", out_valid, 1'b1);
    out_ready = 1'b1;
    drive(vecs[2], 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov", out_valid, 1'b0);
    chk("fl_cnt", xfer_cnt, 8'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl_nothing_%0d", k), out_valid, 1'b0);
    end
    chk("fl_cnt_final", xfer_cnt, 8'd1);

    // Asynchronous reset mid-stream with a stalled result
    out_ready = 1'b0;
    drive(vecs[0], 1'b1);
    step();
    in_valid = 1'b0;
    step();
    chk("mr_pre_ov", out_valid, 1'b1);
    chk("mr_pre_n", n, 5'h0C);
    #2 rst = 1'b0;
    #1;
    chk("mr_ov", out_valid, 1'b0);
    chk("mr_n", n, 5'h00);
    chk("mr_cnt", xfer_cnt, 8'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mr_stale_%0d", k), out_valid, 1'b0);
    end

    // Counter saturation on the CNT_W=2 instance
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) drive(vecs[k], 1'b1);
      else in_valid = 1'b0;
      step();
      if (k >= 1) begin
        chk($sformatf("sat_cnt8_%0d", k), xfer_cnt, k - 1);
        chk($sformatf("sat_cnt2_%0d", k), xfer_cnt2, (k - 1 > 3) ? 3 : k - 1);
      end
    end
    step();
    chk("sat_cnt8_final", xfer_cnt, 8'd5);
    chk("sat_cnt2_final", xfer_cnt2, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
